// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared AES types, round constants and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    CALC  = 2'd2
  } inv_ks_state_t;

  localparam logic [7:0] AES_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Indices outside 1..10 yield zero so the caller never reads past the table.
  function automatic logic [7:0] rcon_byte(input logic [3:0] r);
    logic [7:0] b;
    b = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) b = AES_RCON[r];
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox : combinational AES forward S-box, one byte
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX_TABLE[x];

endmodule

`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
// ============================================================================
// aes_inv_key_sched : reverse AES-128 key schedule, round 10 down to round 0
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key_in,
  input  logic         step,
  output logic [127:0] rk_out,
  output logic [3:0]   rnd,
  output logic         ready,
  output logic         done
);

  inv_ks_state_t state;

  logic [31:0] r_v1, r_v2, r_v3, r_sw;
  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_v3, w_rot, w_sub, w_v0;

  assign w_w0  = rk_out[127:96];
  assign w_w1  = rk_out[95:64];
  assign w_w2  = rk_out[63:32];
  assign w_w3  = rk_out[31:0];
  assign w_v3  = w_w3 ^ w_w2;
  assign w_rot = {w_v3[23:0], w_v3[31:24]};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
        .x (w_rot[8*i +: 8]),
        .y (w_sub[8*i +: 8])
      );
    end
  endgenerate

  // rk_out and rnd are frozen through CALC, so w0 and rcon need no staging.
  assign w_v0 = w_w0 ^ r_sw ^ {rcon_byte(rnd), 24'h000000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rk_out <= '0;
      rnd    <= '0;
      ready  <= 1'b0;
      done   <= 1'b0;
      r_v1   <= '0;
      r_v2   <= '0;
      r_v3   <= '0;
      r_sw   <= '0;
    end else if (kld) begin
      state  <= READY;
      rk_out <= key_in;
      rnd    <= 4'd10;
      ready  <= 1'b1;
      done   <= 1'b0;
    end else begin
      case (state)
        READY: begin
          if (step && rnd != 4'd0) begin
            state <= CALC;
            ready <= 1'b0;
            r_v1  <= w_w1 ^ w_w0;
            r_v2  <= w_w2 ^ w_w1;
            r_v3  <= w_v3;
            r_sw  <= w_sub;
          end
        end
        CALC: begin
          state  <= READY;
          rk_out <= {w_v0, r_v1, r_v2, r_v3};
          rnd    <= rnd - 4'd1;
          ready  <= 1'b1;
          done   <= (rnd == 4'd1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Reverse AES-128 key schedule. It is loaded with the final (round-10) round key and steps backwards one round per request, down to the cipher key (round 0). It consumes round constants in reverse order: 0x36, 0x1b, 0x80 … 0x01. It sits beside the inverse cipher datapath and supplies round keys in decryption order without storing all eleven keys.

## Interface
- No parameters; AES-128 only.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `kld`  in  1  load `key_in` as the round-10 key.
- `key_in`  in  128  round-10 key; word 0 in [127:96].
- `step`  in  1  request the previous round key.
- `rk_out`  out  128  current round key; word 0 in [127:96].
- `rnd`  out  4  round index of `rk_out`, 10 down to 0.
- `ready`  out  1  `rk_out` valid and a step can be accepted.
- `done`  out  1  `rnd` == 0 and `ready`.

## Operation
- **States:** IDLE, READY, CALC.
  - IDLE → READY on `kld`.
  - READY → CALC on `step` && `rnd` != 0.
  - CALC → READY unconditionally.
  - Any state → READY on `kld`.
  - Any state → IDLE on `rst`.
- **Load:** `rk_out` <= `key_in`, `rnd` <= 10.
- **Step, with current words w0..w3 and r = `rnd`:**
  - v3 = w3^w2, v2 = w2^w1, v1 = w1^w0.
  - v0 = w0 ^ SubWord(RotWord(v3)) ^ {rcon(r), 24'h0}.
  - rcon(1..10) = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - rcon for any other index = 00; this value is never used in operation.
- **CALC cycle:**
  - First half: v1..v3 and SubWord(RotWord(v3)) are registered.
  - Second half: v0 is formed, `rk_out` is updated, and `rnd` is decremented.
  - The split keeps the S-box off the same path as the 4-way XOR.
- **Ignored requests:**
  - `step` in IDLE, in CALC, or in READY with `rnd` == 0 has no effect.
  - No error is flagged.
- **Priority:**
  - `rst` > `kld` > `step`.
  - `kld` during CALC aborts the computation; the new key wins and the partial result is discarded.
- **Reset values:** `rk_out` = 0, `rnd` = 0, `ready` = 0, `done` = 0, internal pipeline registers = 0, state IDLE.
- `rk_out` and `rnd` change only on a load or on CALC completion; they are stable at all other times.

## Timing
- **Load:** `kld` sampled at edge n → `rk_out`/`rnd` = `key_in`/10 and `ready` = 1 after edge n.
- **Step:**
  - `step` && `ready` sampled at edge n → `ready` = 0 after edge n (CALC).
  - The previous key is on `rk_out` with `ready` = 1 after edge n+1.
  - Step latency is 2 cycles; throughput is one round key per 2 cycles.
- Holding `step` high continuously walks 10 → 0 in 20 cycles after load, then stays at `rnd` = 0 with `done` = 1.
- **`done`:** asserted with `ready` after the CALC that produces `rnd` = 0; it stays high until the next `kld` or `rst`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package `aes_pkg`:**
  - State enum `inv_ks_state_t` (IDLE, READY, CALC).
  - Constant array `AES_RCON[1:10]` of 8-bit values.
  - Function `rcon_byte(logic [3:0])`, returning 00 outside 1..10.
  - The existing forward round-constant generator will migrate to the same constants.
- **Sub-module:** four instances of the existing `aes_sbox` (8-bit in, 8-bit out, combinational) implement SubWord.
  - No other sub-module.

## Test plan
- **FIPS-197 A.1 single step:**
  - Load d014f9a8_c9ee2589_e13f0cc8_b6630ca6 and issue one `step`.
  - 2 cycles later, required: `rk_out` = ac7766f3_19fadc21_28d12941_575c006e, `rnd` = 9.
- **Full walk:**
  - Same load with `step` held high.
  - After 20 cycles, required: `rk_out` = 2b7e1516_28aed2a6_abf71588_09cf4f3c, `rnd` = 0, `done` = 1.
  - Each intermediate key must match the FIPS-197 expansion w[4r..4r+3].
- **Ignored steps:**
  - `step` before any `kld` leaves `ready` = 0 and `rk_out` = 0.
  - `step` at `rnd` = 0 leaves the outputs unchanged for 5 cycles.
- **Load during CALC:**
  - Assert `kld` with a new key in the CALC cycle.
  - Required next cycle: `rk_out` = new key, `rnd` = 10, `ready` = 1; the aborted result never appears.
- **Reset mid-walk:**
  - `rst` at `rnd` = 5 during CALC.
  - Required next cycle: all outputs 0 and state IDLE; a subsequent `step` is ignored.
- **Random cross-check:** for 1000 random cipher keys, compute the forward expansion in the bench, load w[40..43], walk back, and compare every round key.
